// File: rtl/ecc_28_22_pkg.sv
// ecc_28_22_pkg: widths, code constants and shared types for the inverted (28,22) SECDED read path
package ecc_28_22_pkg;
    localparam int DataW = 22;
    localparam int CodeW = 28;
    localparam int SyndW = 6;
    localparam logic [CodeW-1:0] InvConst = 28'ha800000;
    // Parity mask for check bit s (stored at bit DataW+s); only data bits are set.
    localparam logic [SyndW-1:0][CodeW-1:0] EncMask = {
        28'h03ED348, 28'h03DAAA4, 28'h03B6592, 28'h0271C71, 28'h010FC0F, 28'h03003FF
    };
    typedef enum logic [1:0] {NONE = 2'd0, CORR = 2'd1, UNCORR = 2'd2} err_e;
    typedef enum logic {IDLE = 1'b0, WB = 1'b1} state_e;
    // Syndrome produced by a single flip of data bit i.
    function automatic logic [SyndW-1:0] syn_col(input int i);
        for (int s = 0; s < SyndW; s++) syn_col[s] = EncMask[s][i];
    endfunction
endpackage

// File: rtl/prim_secded_inv_28_22_dec.sv
// prim_secded_inv_28_22_dec: inverted (28,22) SECDED decoder
//   data_i: raw codeword; data_o: corrected data; err_o: [0] correctable, [1] uncorrectable
module prim_secded_inv_28_22_dec
    import ecc_28_22_pkg::*;
(
    input  logic [CodeW-1:0] data_i,
    output logic [DataW-1:0] data_o,
    output logic [1:0]       err_o
);
    logic [CodeW-1:0] raw;
    logic [SyndW-1:0] syn;
    assign raw = data_i ^ InvConst;
    always_comb begin
        for (int s = 0; s < SyndW; s++)
            syn[s] = ^(raw & (EncMask[s] | (CodeW'(1) << (DataW + s))));
        for (int i = 0; i < DataW; i++) data_o[i] = raw[i] ^ (syn == syn_col(i));
    end
    // Odd-weight syndrome is a single error; nonzero even weight is a double error.
    assign err_o = {~^syn & |syn, ^syn};
endmodule

// File: rtl/prim_secded_inv_28_22_enc.sv
// prim_secded_inv_28_22_enc: inverted (28,22) SECDED encoder
//   data_i: 22-bit data; data_o: 28-bit codeword with check bits inverted by InvConst
module prim_secded_inv_28_22_enc
    import ecc_28_22_pkg::*;
(
    input  logic [DataW-1:0] data_i,
    output logic [CodeW-1:0] data_o
);
    logic [SyndW-1:0] chk;
    always_comb begin
        for (int s = 0; s < SyndW; s++) chk[s] = ^(CodeW'(data_i) & EncMask[s]);
    end
    assign data_o = {chk, data_i} ^ InvConst;
endmodule

// File: rtl/ecc_rd_resp_28_22.sv
// ecc_rd_resp_28_22: ECC read-response stage with scrub write-back and saturating error counters
//   in_*  : codeword input (valid/ready) with source address
//   rsp_* : registered corrected data and error class toward the consumer
//   wb_*  : scrub write of the re-encoded codeword after a correctable error
//   clr_cnt_i / corr_cnt_o / uncorr_cnt_o : error counters for CSR readout
module ecc_rd_resp_28_22
    import ecc_28_22_pkg::*;
#(
    parameter int AddrWidth = 10,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [CodeW-1:0]     in_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataW-1:0]     rsp_data_o,
    output logic [1:0]           rsp_err_o,
    output logic                 wb_req_o,
    input  logic                 wb_gnt_i,
    output logic [AddrWidth-1:0] wb_addr_o,
    output logic [CodeW-1:0]     wb_wdata_o,
    input  logic                 clr_cnt_i,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o
);
    state_e           state_q, state_d;
    logic             accept;
    logic [DataW-1:0] dec_data;
    logic [1:0]       dec_err;
    logic [CodeW-1:0] enc_code;
    err_e             dec_cls;

    prim_secded_inv_28_22_dec u_dec (
        .data_i(in_rdata_i),
        .data_o(dec_data),
        .err_o (dec_err)
    );

    prim_secded_inv_28_22_enc u_enc (
        .data_i(dec_data),
        .data_o(enc_code)
    );

    assign dec_cls    = err_e'(dec_err);
    // Stalling input during a scrub keeps a re-read of the stale location behind the write.
    assign in_ready_o = (~rsp_valid_o | rsp_ready_i) & (state_q == IDLE);
    assign accept     = in_valid_i & in_ready_o;
    assign wb_req_o   = (state_q == WB);

    always_comb begin
        state_d = state_q;
        state_d = (state_q == WB) ? (wb_gnt_i ? IDLE : WB)
                                  : ((accept && dec_cls == CORR) ? WB : IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= '0;
            wb_addr_o   <= '0;
            wb_wdata_o  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= dec_data;
                rsp_err_o   <= dec_err;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            if (accept && dec_cls == CORR) begin
                wb_addr_o  <= in_addr_i;
                wb_wdata_o <= enc_code;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else begin
            if (accept && dec_cls == CORR && ~&corr_cnt_o)
                corr_cnt_o <= corr_cnt_o + CntWidth'(1);
            if (accept && dec_cls == UNCORR && ~&uncorr_cnt_o)
                uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
        end
    end
endmodule
